mdu_scheduler: RTL and testbench
================================

// Module: mdu_scheduler
// PURPOSE
//  Sequencing controller for the EXE-stage multiply/divide resource (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
//  Accepts one op from EXE, runs it on a pipelined multiplier or an iterative radix-2 divider,
//  and holds EXE with a stall until the result is ready. Then issues a single HI/LO write pulse
//  to the external hilo register file. A pipeline flush aborts the op with no architectural effect.
// PARAMETERS
//  MUL_LAT    1   extra multiplier cycles after accept (1..4)
//  DIV_ITERS  32  divider iterations, one quotient bit per cycle (fixed at 32 for a 32-bit ISA)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  op_valid   in   1   EXE holds a valid md op this cycle
//  op_code    in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others = no-op
//  src1       in   32  rs value, forwarded (dividend / multiplicand / MTHI-MTLO data)
//  src2       in   32  rt value, forwarded (divisor / multiplier)
//  flush      in   1   kill the in-flight op (exception / redirect)
//  stall      out  1   EXE must hold its instruction and must not advance
//  busy       out  1   FSM is not IDLE
//  hi_we      out  1   one-cycle HI write strobe
//  lo_we      out  1   one-cycle LO write strobe
//  hi_wdata   out  32  HI write data
//  lo_wdata   out  32  LO write data
// BEHAVIOUR
//  Reset: state = IDLE. stall, busy, hi_we and lo_we = 0. hi_wdata, lo_wdata = 0. Divider state cleared.
//  FSM states: IDLE, MUL, DIV, DONE. Cycle 0 is the cycle the op is accepted.
//  IDLE, op_valid and a mul/div op, flush = 0:
//   - Latch src1, src2 and the op; stall = 1 combinationally in that same cycle.
//   - MULT/MULTU go to MUL. DIV/DIVU go to DIV.
//  MUL: counter runs MUL_LAT cycles, then -> DONE at cycle MUL_LAT+1. Stall is high for cycles 0..MUL_LAT.
//   - MULT uses a 33x33 signed product of sign-extended operands.
//   - MULTU uses zero-extended operands. HI = prod[63:32], LO = prod[31:0].
//  DIV: cycle 0 latches operands. Cycles 1..32 perform 32 restoring iterations on magnitudes.
//   - DONE at cycle 33; stall is high for cycles 0..32.
//   - Signed quotient is negated when the operand signs differ.
//   - Signed remainder takes the sign of the dividend. HI = remainder, LO = quotient.
//   - Divisor 0: quotient magnitude 32'hFFFF_FFFF, remainder = dividend, then sign rules apply. No trap.
//   - 0x8000_0000 / -1 (signed): LO = 0x8000_0000, HI = 0.
//  DONE (one cycle): stall = 0, hi_we = lo_we = 1 with the results, then -> IDLE.
//   - EXE advances in this cycle. The same instruction is never re-accepted, because the FSM is not IDLE.
//  MTHI/MTLO in IDLE: no stall. hi_we (resp. lo_we) = 1 in the same cycle, with data = src1.
//  op_valid with a no-op code: ignored, stall = 0.
//  Ops arriving while not IDLE are ignored; the held EXE op is the same instruction.
//  flush:
//   - In any state, the next state is IDLE and the counter and divider are cleared.
//   - hi_we = lo_we = 0 in the flush cycle, including DONE and MTHI/MTLO.
//   - stall = 0 in the flush cycle.
//  Back-to-back: a new op may be accepted in the cycle right after DONE.
//  Reset mid-operation: same as flush, and all outputs return to their reset values.
// STRUCTURE
//  mdu_pkg holds:
//   - op_code localparams (OP_MULT..OP_MTLO) and FSM state encodings
//   - DIV_ITERS and the counter width
//  Sub-module div_iter (radix-2 restoring, unsigned core):
//   - Inputs: start, abort, dividend_abs, divisor_abs.
//   - Outputs: done, q, r.
//  The scheduler does sign fix-up and the multiplier pipeline inline.
// TESTING
//  1. MULT src1=-3, src2=5 -> stall cycles 0..1; at cycle 2 hi_we=lo_we=1, HI=FFFF_FFFF, LO=FFFF_FFF1.
//  2. DIVU 100/7 -> stall 33 cycles; at cycle 33 LO=14, HI=2. DIV -7/2 -> LO=FFFF_FFFD, HI=FFFF_FFFF.
//  3. DIV 0x8000_0000/-1 -> LO=8000_0000, HI=0. DIVU 5/0 -> LO=FFFF_FFFF, HI=5. Neither hangs.
//  4. DIV issued, flush at cycle 10 -> IDLE next cycle, no hi_we or lo_we ever pulses.
//     A following MULTU 2*3 completes with LO=6.
//  5. MTLO src1=0xABCD -> lo_we=1 in cycle 0, lo_wdata=0xABCD, stall=0.
//     Back-to-back DIVU after DONE is accepted in the next cycle.
//  6. reset asserted mid-DIV -> next cycle busy=0, stall=0, all strobes 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the EXE-stage multiply/divide scheduler:
// op codes, FSM state encoding and divider iteration sizing.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude of a 32-bit operand; unsigned ops pass straight through.
    function automatic logic [31:0] abs_val(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// A divisor of zero naturally yields q = all ones and r = dividend.
module div_iter
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend_abs,
    input  logic [31:0] divisor_abs,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_quo;
    logic [31:0]      r_rem;
    logic [31:0]      r_dvsr;

    logic [32:0]      w_shift;
    logic [31:0]      w_sub;
    logic             w_fits;

    // Partial remainder never exceeds 32 bits, so the subtraction can wrap mod 2^32.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_fits  = (w_shift >= {1'b0, r_dvsr});
    assign w_sub   = w_shift[31:0] - r_dvsr;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_quo    <= dividend_abs;
            r_rem    <= '0;
            r_dvsr   <= divisor_abs;
        end else if (r_active) begin
            r_rem <= w_fits ? w_sub : w_shift[31:0];
            r_quo <= {r_quo[30:0], w_fits};
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
                r_active <= 1'b0;
            end
        end
    end

    // High during the final iteration; q/r are valid from the following cycle.
    assign done = r_active && (r_cnt == CNT_W'(DIV_ITERS - 1));
    assign q    = r_quo;
    assign r    = r_rem;

endmodule

// File: rtl/mdu_scheduler.sv
// EXE-stage multiply/divide sequencer: stalls EXE while a MULT/DIV runs,
// then emits one HI/LO write pulse; flush or reset abandons the op silently.
module mdu_scheduler
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_q_neg;
    logic               r_r_neg;
    logic signed [32:0] r_mul_a;
    logic signed [32:0] r_mul_b;
    logic [63:0]        r_prod_pipe [MUL_LAT];

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_accept;
    logic               w_div_start;
    logic               w_div_done;
    logic [31:0]        w_dvd_abs;
    logic [31:0]        w_dvs_abs;
    logic [31:0]        w_q;
    logic [31:0]        w_r;
    logic [31:0]        w_div_hi;
    logic [31:0]        w_div_lo;
    logic [63:0]        w_prod;

    assign w_is_mul  = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign w_is_div  = (op_code == OP_DIV)  || (op_code == OP_DIVU);
    assign w_signed  = (op_code == OP_MULT) || (op_code == OP_DIV);
    assign w_dvd_abs = abs_val(src1, w_signed);
    assign w_dvs_abs = abs_val(src2, w_signed);

    // 33x33 signed product; only the low 64 bits are architecturally visible.
    assign w_prod = 64'(r_mul_a) * 64'(r_mul_b);

    // Quotient sign follows operand sign mismatch, remainder follows the dividend.
    assign w_div_lo = r_q_neg ? (~w_q + 32'd1) : w_q;
    assign w_div_hi = r_r_neg ? (~w_r + 32'd1) : w_r;

    div_iter u_div_iter (
        .clk          (clk),
        .reset        (reset),
        .start        (w_div_start),
        .abort        (flush),
        .dividend_abs (w_dvd_abs),
        .divisor_abs  (w_dvs_abs),
        .done         (w_div_done),
        .q            (w_q),
        .r            (w_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (r_state == ST_MUL && !flush) ? r_cnt + CNT_W'(1) : '0;
            if (w_accept) begin
                r_is_div <= w_is_div;
                r_q_neg  <= w_signed & (src1[31] ^ src2[31]);
                r_r_neg  <= w_signed & src1[31];
                r_mul_a  <= {w_signed & src1[31], src1};
                r_mul_b  <= {w_signed & src2[31], src2};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                r_prod_pipe[i] <= '0;
            end
        end else begin
            r_prod_pipe[0] <= w_prod;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_prod_pipe[i] <= r_prod_pipe[i-1];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_div_start  = 1'b0;
        stall        = 1'b0;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        hi_wdata     = '0;
        lo_wdata     = '0;

        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    if (w_is_mul) begin
                        w_accept     = 1'b1;
                        stall        = 1'b1;
                        w_state_next = ST_MUL;
                    end else if (w_is_div) begin
                        w_accept     = 1'b1;
                        w_div_start  = 1'b1;
                        stall        = 1'b1;
                        w_state_next = ST_DIV;
                    end else if (op_code == OP_MTHI) begin
                        hi_we    = 1'b1;
                        hi_wdata = src1;
                    end else if (op_code == OP_MTLO) begin
                        lo_we    = 1'b1;
                        lo_wdata = src1;
                    end
                end
            end
            ST_MUL: begin
                stall = 1'b1;
                if (r_cnt == CNT_W'(MUL_LAT - 1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DIV: begin
                stall = 1'b1;
                if (w_div_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                hi_we        = 1'b1;
                lo_we        = 1'b1;
                hi_wdata     = r_is_div ? w_div_hi : r_prod_pipe[MUL_LAT-1][63:32];
                lo_wdata     = r_is_div ? w_div_lo : r_prod_pipe[MUL_LAT-1][31:0];
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Flush and reset both kill the op with no architectural side effect.
        if (flush || reset) begin
            w_state_next = ST_IDLE;
            w_accept     = 1'b0;
            w_div_start  = 1'b0;
            stall        = 1'b0;
            hi_we        = 1'b0;
            lo_we        = 1'b0;
            hi_wdata     = '0;
            lo_wdata     = '0;
        end
    end

    assign busy = (r_state != ST_IDLE) && !reset;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Bench for mdu_scheduler: directed cases then random ops against an
// arithmetic reference model of HI/LO results and cycle-exact stall timing.
module tb_mdu_scheduler;

    localparam int MUL_LAT   = 1;
    localparam int DIV_CYC   = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    mdu_scheduler #(.MUL_LAT(MUL_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_code  (op_code),
        .src1     (src1),
        .src2     (src2),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference HI/LO from plain integer arithmetic and the ISA corner rules.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qq = sa / sb;
                rr = sa % sb;
                return {rr[31:0], qq[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {a, a};
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op_valid = 1'b0; flush = 1'b0; reset = 1'b0;
            #1;
            chk("idle_busy",  busy,  1'b0);
            chk("idle_stall", stall, 1'b0);
            chk("idle_hi_we", hi_we, 1'b0);
            chk("idle_lo_we", lo_we, 1'b0);
        end
    endtask

    // Holds the op on the EXE inputs until DONE (or the kill cycle), checking every cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int kill_at, input bit kill_rst);
        int lat;
        if (op >= 3'd4) begin
            @(negedge clk);
            op_valid = 1'b1; op_code = op; src1 = a; src2 = b;
            flush = (kill_at == 0) && !kill_rst;
            reset = (kill_at == 0) && kill_rst;
            #1;
            chk("mt_stall", stall, 1'b0);
            chk("mt_busy",  busy,  1'b0);
            chk("mt_hi_we", hi_we, (op == 3'd4) && (kill_at != 0));
            chk("mt_lo_we", lo_we, (op == 3'd5) && (kill_at != 0));
            if (op == 3'd4 && kill_at != 0) chk("mthi_data", hi_wdata, a);
            if (op == 3'd5 && kill_at != 0) chk("mtlo_data", lo_wdata, a);
            $display("op=%0d a=%h b=%h kill=%0d single-cycle", op, a, b, kill_at);
            return;
        end
        lat = (op < 3'd2) ? MUL_LAT + 1 : DIV_CYC;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            op_valid = 1'b1; op_code = op; src1 = a; src2 = b;
            flush = (c == kill_at) && !kill_rst;
            reset = (c == kill_at) && kill_rst;
            #1;
            if (c == kill_at) begin
                chk("kill_stall", stall, 1'b0);
                chk("kill_hi_we", hi_we, 1'b0);
                chk("kill_lo_we", lo_we, 1'b0);
                @(negedge clk);
                op_valid = 1'b0; flush = 1'b0; reset = 1'b0;
                #1;
                chk("post_kill_busy",  busy,  1'b0);
                chk("post_kill_stall", stall, 1'b0);
                chk("post_kill_hi_we", hi_we, 1'b0);
                chk("post_kill_lo_we", lo_we, 1'b0);
                $display("op=%0d a=%h b=%h killed at cycle %0d by %s", op, a, b, c, kill_rst ? "reset" : "flush");
                return;
            end
            chk("busy",  busy,  c != 0);
            chk("stall", stall, c < lat);
            chk("hi_we", hi_we, c == lat);
            chk("lo_we", lo_we, c == lat);
            if (c == lat) begin
                chk("hi_wdata", hi_wdata, ehi);
                chk("lo_wdata", lo_wdata, elo);
            end
        end
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h (expected %h %h)", op, a, b, hi_wdata, lo_wdata, ehi, elo);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] exp_hl;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rkill;
        int          rlat;

        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; src1 = '0; src2 = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",     busy,     1'b0);
        chk("rst_stall",    stall,    1'b0);
        chk("rst_hi_we",    hi_we,    1'b0);
        chk("rst_lo_we",    lo_we,    1'b0);
        chk("rst_hi_wdata", hi_wdata, 32'd0);
        chk("rst_lo_wdata", lo_wdata, 32'd0);
        idle(2);

        run_op(3'd0, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1, 1'b0);
        idle(1);
        run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, -1, 1'b0);
        idle(1);
        run_op(3'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 1'b0);
        idle(1);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1, 1'b0);
        idle(1);
        run_op(3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, -1, 1'b0);
        idle(1);

        run_op(3'd2, 32'd1000, 32'd3, 32'd0, 32'd0, 10, 1'b0);
        idle(3);
        run_op(3'd1, 32'd2, 32'd3, 32'd0, 32'd6, -1, 1'b0);
        idle(1);

        run_op(3'd5, 32'h0000_ABCD, 32'd0, 32'd0, 32'd0, -1, 1'b0);
        run_op(3'd3, 32'd50, 32'd6, 32'd2, 32'd8, -1, 1'b0);
        run_op(3'd3, 32'd77, 32'd10, 32'd7, 32'd7, -1, 1'b0);
        idle(1);

        run_op(3'd2, 32'd1234, 32'd5, 32'd0, 32'd0, 15, 1'b1);
        idle(2);

        run_op(3'd6, 32'd9, 32'd9, 32'd0, 32'd0, -1, 1'b0);
        run_op(3'd7, 32'd9, 32'd9, 32'd0, 32'd0, -1, 1'b0);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            rop    = 3'($urandom_range(0, 7));
            ra     = pick_val();
            rb     = pick_val();
            exp_hl = ref_md(rop, ra, rb);
            rlat   = (rop < 3'd2) ? MUL_LAT + 1 : (rop < 3'd4 ? DIV_CYC : 0);
            rkill  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rlat)) : -1;
            run_op(rop, ra, rb, exp_hl[63:32], exp_hl[31:0], rkill, 1'b0);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
